instr_register_arbiter: RTL and testbench
=========================================

INSTR_REGISTER_ARBITER -- requirements
Module: instr_register_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 32, entries used (2..32); pointers wrap DEPTH-1 -> 0.
REQ-002 SHALL import instr_register_pkg for opcode_t, operand_t and address_t.
REQ-003 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: req_valid  in  2  per-requester write request.
REQ-006 SHALL have port: req_ready  out  2  per-requester accept; combinational.
REQ-007 SHALL have port: req_opcode  in  2 x opcode_t  requester opcodes.
REQ-008 SHALL have port: req_operand_a  in  2 x operand_t  requester operand A.
REQ-009 SHALL have port: req_operand_b  in  2 x operand_t  requester operand B.
REQ-010 SHALL have port: load_en  out  1  write enable to instruction register.
REQ-011 SHALL have port: write_pointer  out  address_t  write address.
REQ-012 SHALL have port: opcode / operand_a / operand_b  out  opcode_t / operand_t / operand_t  write data.
REQ-013 SHALL have port: read_pointer  out  address_t  head entry address.
REQ-014 SHALL have port: pop_valid  out  1  head entry committed and readable.
REQ-015 SHALL have port: pop_ready  in  1  consumer accepts head entry.
REQ-016 SHALL have port: count  out  6  committed entries; full  out  1; empty  out  1.

Function
REQ-017 SHALL run FSM IDLE / LOAD / FULL: IDLE->LOAD on accept; LOAD->LOAD on back-to-back accept; LOAD->IDLE when no accept; any->FULL when reserved == DEPTH; FULL->IDLE on pop.
REQ-018 SHALL keep reserved = committed + in-flight writes; req_ready[i] = 0 for both requesters while reserved == DEPTH.
REQ-019 SHALL grant at most one requester per cycle; single valid is granted; both valid grants the requester not granted last (round-robin; requester 0 wins after reset).
REQ-020 SHALL, on accept at edge E, drive load_en = 1, write_pointer = wp, data = granted request for the cycle after E; wp increments at E.
REQ-021 SHALL increment committed count at E+1 (DUT capture edge); pop_valid = (count != 0).
REQ-022 SHALL, on pop_valid & pop_ready, advance read_pointer at that edge; pop_ready with empty is ignored.
REQ-023 SHALL, on simultaneous commit and pop, leave count unchanged; accept and pop at reserved == DEPTH not allowed (no bypass).
REQ-024 SHALL hold load_en = 0 whenever no write is in flight; data outputs hold last value.

Reset
REQ-025 SHALL asynchronously on reset = 1: state IDLE, load_en 0, write_pointer 0, read_pointer 0, count 0, empty 1, full 0, pop_valid 0, req_ready 0, last grant = requester 1, opcode/operands 0.
REQ-026 SHALL, on reset mid-write, drop the in-flight write; load_en falls without waiting for clk.

Configuration
REQ-027 SHALL, with INSTR_ARB_FIXED_PRIO_EN defined, use fixed priority (requester 0 always wins); without it, round-robin per REQ-019.

Verification
REQ-028 SHALL verify reset: assert reset mid-LOAD -> load_en 0 immediately, count 0, pointers 0, empty 1.
REQ-029 SHALL verify arbitration: both valid for 4 cycles -> grants 0,1,0,1; write_pointer 0,1,2,3; with INSTR_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
REQ-030 SHALL verify latency: accept at edge E with opcode ADD, operands 5 and 3 -> load_en high cycle E..E+1, count 1 and pop_valid 1 after E+1, DUT result 8 at read_pointer 0.
REQ-031 SHALL verify full: 32 accepts, no pops -> full 1, req_ready 00; one pop -> next accept goes to write_pointer 0 (wrap).
REQ-032 SHALL verify simultaneous: count 5, commit and pop same edge -> count stays 5, read_pointer +1.
REQ-033 SHALL verify DEPTH = 4: 5 requests with pops -> write_pointer sequence 0,1,2,3,0.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write-side arbiter.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

endpackage

// File: rtl/instr_register_arbiter.sv
// Two-requester write arbiter and ring-buffer pointer manager for the instruction register; a write lands one cycle after accept.
// req_ready drops for both requesters once committed + in-flight entries reach DEPTH; INSTR_ARB_FIXED_PRIO_EN selects fixed priority.
module instr_register_arbiter
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  opcode_t  [1:0] req_opcode,
  input  operand_t [1:0] req_operand_a,
  input  operand_t [1:0] req_operand_b,
  output logic           load_en,
  output address_t       write_pointer,
  output opcode_t        opcode,
  output operand_t       operand_a,
  output operand_t       operand_b,
  output address_t       read_pointer,
  output logic           pop_valid,
  input  logic           pop_ready,
  output logic [5:0]     count,
  output logic           full,
  output logic           empty
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [6:0] CAP       = 7'(DEPTH);
  localparam address_t   LAST_ADDR = address_t'(DEPTH - 1);

  state_t     state;
  address_t   wp;
  logic       last_grant;
  logic [1:0] grant;
  logic [6:0] reserved;
  logic [6:0] reserved_next;
  logic       at_cap;
  logic       accept;
  logic       sel;
  logic       pop_fire;

  // An in-flight write already owns a slot, so capacity counts it.
  assign reserved      = {1'b0, count} + {6'd0, load_en};
  assign at_cap        = (reserved == CAP);
  assign reserved_next = reserved + {6'd0, accept} - {6'd0, pop_fire};

  always_comb begin
    grant = 2'b00;
`ifdef INSTR_ARB_FIXED_PRIO_EN
    if (req_valid[0])      grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
`else
    if (req_valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    else                    grant = req_valid;
`endif
  end

  assign req_ready = (reset || at_cap) ? 2'b00 : grant;
  assign accept    = |(req_valid & req_ready);
  assign sel       = req_ready[1];
  assign pop_valid = (count != 6'd0);
  assign empty     = (count == 6'd0);
  assign pop_fire  = pop_valid & pop_ready;
  assign full      = (state == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      load_en       <= 1'b0;
      write_pointer <= '0;
      wp            <= '0;
      read_pointer  <= '0;
      count         <= '0;
      last_grant    <= 1'b1;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
    end else begin
      load_en <= accept;
      if (accept) begin
        write_pointer <= wp;
        wp            <= (wp == LAST_ADDR) ? '0 : wp + 1'b1;
        opcode        <= req_opcode[sel];
        operand_a     <= req_operand_a[sel];
        operand_b     <= req_operand_b[sel];
        last_grant    <= sel;
      end

      if (pop_fire)
        read_pointer <= (read_pointer == LAST_ADDR) ? '0 : read_pointer + 1'b1;

      // The register captures the write at the edge after accept; count follows it.
      case ({load_en, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (reserved_next == CAP) state <= FULL;
          else if (accept)          state <= LOAD;
        end
        LOAD: begin
          if (reserved_next == CAP) state <= FULL;
          else if (!accept)         state <= IDLE;
        end
        FULL: begin
          if (pop_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_register_arbiter.sv
// Bench for instr_register_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_instr_register_arbiter;
  import instr_register_pkg::*;

  localparam int DEPTH = 32;

  logic           clk;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  opcode_t  [1:0] req_opcode;
  operand_t [1:0] req_operand_a;
  operand_t [1:0] req_operand_b;
  logic           load_en;
  address_t       write_pointer;
  opcode_t        opcode;
  operand_t       operand_a;
  operand_t       operand_b;
  address_t       read_pointer;
  logic           pop_valid;
  logic           pop_ready;
  logic [5:0]     count;
  logic           full;
  logic           empty;

  // Second instance with a small ring for wrap checks.
  logic [1:0]     q_valid;
  logic [1:0]     q_ready;
  logic           q_load_en;
  address_t       q_wp;
  opcode_t        q_op;
  operand_t       q_a;
  operand_t       q_b;
  address_t       q_rp;
  logic           q_pop_valid;
  logic           q_pop_ready;
  logic [5:0]     q_count;
  logic           q_full;
  logic           q_empty;

  instr_register_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_pointer(read_pointer), .pop_valid(pop_valid), .pop_ready(pop_ready),
    .count(count), .full(full), .empty(empty)
  );

  instr_register_arbiter #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(rst),
    .req_valid(q_valid), .req_ready(q_ready),
    .req_opcode(req_opcode), .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .load_en(q_load_en), .write_pointer(q_wp),
    .opcode(q_op), .operand_a(q_a), .operand_b(q_b),
    .read_pointer(q_rp), .pop_valid(q_pop_valid), .pop_ready(q_pop_ready),
    .count(q_count), .full(q_full), .empty(q_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: committed entries kept as a queue of their addresses.
  address_t m_q[$];
  int       m_rp, m_wp, m_wout, m_last;
  bit       m_infl;
  opcode_t  m_op;
  operand_t m_a, m_b;

  function automatic logic [1:0] exp_ready(input logic [1:0] v);
    int free_slots;
    free_slots = DEPTH - m_q.size() - int'(m_infl);
    if (rst || free_slots == 0 || v == 2'b00) return 2'b00;
    if (v != 2'b11) return v;
`ifdef INSTR_ARB_FIXED_PRIO_EN
    return 2'b01;
`else
    return (m_last == 1) ? 2'b01 : 2'b10;
`endif
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_rp = 0; m_wp = 0; m_wout = 0; m_last = 1; m_infl = 1'b0;
    m_op = ZERO; m_a = '0; m_b = '0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin : upd
        logic [1:0] r;
        int         g;
        bit         popf;
        r    = exp_ready(req_valid);
        popf = (m_q.size() != 0) && pop_ready;
        if (m_infl) m_q.push_back(address_t'(m_wout));
        if (popf) begin
          void'(m_q.pop_front());
          m_rp = (m_rp + 1) % DEPTH;
        end
        m_infl = |(req_valid & r);
        if (m_infl) begin
          g      = r[1] ? 1 : 0;
          m_wout = m_wp;
          m_wp   = (m_wp + 1) % DEPTH;
          m_op   = req_opcode[g];
          m_a    = req_operand_a[g];
          m_b    = req_operand_b[g];
          m_last = g;
        end
      end
    end
  end

  // Stand-in instruction register fed by the write port.
  opcode_t  ir_op [DEPTH];
  operand_t ir_a  [DEPTH];
  operand_t ir_b  [DEPTH];

  initial begin
    forever begin
      @(posedge clk);
      if (load_en === 1'b1) begin
        ir_op[write_pointer] = opcode;
        ir_a[write_pointer]  = operand_a;
        ir_b[write_pointer]  = operand_b;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cmp("req_ready",     req_ready, exp_ready(req_valid));
      cmp("load_en",       load_en, m_infl);
      cmp("write_pointer", write_pointer, m_wout);
      cmp("opcode",        opcode, m_op);
      cmp("operand_a",     operand_a, m_a);
      cmp("operand_b",     operand_b, m_b);
      cmp("read_pointer",  read_pointer, m_rp);
      cmp("count",         count, m_q.size());
      cmp("pop_valid",     pop_valid, m_q.size() != 0);
      cmp("empty",         empty, m_q.size() == 0);
      cmp("full",          full, (m_q.size() + int'(m_infl)) == DEPTH);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int          exp_a [4];
  int          exp_q [5];
  logic [1:0]  tv_valid [8];
  logic        tv_pop [8];

  initial begin
`ifdef INSTR_ARB_FIXED_PRIO_EN
    exp_a = '{10, 10, 10, 10};
`else
    exp_a = '{10, 20, 10, 20};
`endif
    exp_q    = '{0, 1, 2, 3, 0};
    tv_valid = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01};
    tv_pop   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    req_valid = 2'b11;
    pop_ready = 1'b1;
    q_valid = 2'b00;
    q_pop_ready = 1'b0;
    req_opcode    = '{PASSB, PASSA};
    req_operand_a = '{32'sd20, 32'sd10};
    req_operand_b = '{32'sd2, 32'sd1};

    // Reset state, with requests and pops pending.
    step();
    step();
    cmp("rst_req_ready", req_ready, 2'b00);
    cmp("rst_load_en", load_en, 0);
    cmp("rst_count", count, 0);
    cmp("rst_empty", empty, 1);
    cmp("rst_full", full, 0);
    cmp("rst_pop_valid", pop_valid, 0);
    cmp("rst_wp", write_pointer, 0);
    cmp("rst_rp", read_pointer, 0);
    cmp("rst_opcode", opcode, ZERO);
    rst = 1'b0;
    pop_ready = 1'b0;

    // Both requesters valid for four cycles.
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("arb_load_en", load_en, 1);
      cmp("arb_wp", write_pointer, i);
      cmp("arb_grant_a", operand_a, exp_a[i]);
    end
    req_valid = 2'b00;

    // Reset while a write is in flight.
    #2 rst = 1'b1;
    #1;
    cmp("midrst_load_en", load_en, 0);
    cmp("midrst_count", count, 0);
    cmp("midrst_wp", write_pointer, 0);
    cmp("midrst_rp", read_pointer, 0);
    cmp("midrst_empty", empty, 1);
    step();
    rst = 1'b0;

    // Single ADD 5,3: write one cycle after accept, commit the cycle after.
    req_valid        = 2'b01;
    req_opcode[0]    = ADD;
    req_operand_a[0] = 32'sd5;
    req_operand_b[0] = 32'sd3;
    step();
    req_valid = 2'b00;
    cmp("lat_load_en_e", load_en, 1);
    cmp("lat_wp", write_pointer, 0);
    cmp("lat_count_e", count, 0);
    cmp("lat_pop_valid_e", pop_valid, 0);
    step();
    cmp("lat_load_en_e1", load_en, 0);
    cmp("lat_count_e1", count, 1);
    cmp("lat_pop_valid_e1", pop_valid, 1);
    cmp("lat_rp", read_pointer, 0);
    cmp("lat_ir_op", ir_op[read_pointer], ADD);
    cmp("lat_result", ir_a[read_pointer] + ir_b[read_pointer], 8);
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    cmp("lat_pop_count", count, 0);
    cmp("lat_pop_rp", read_pointer, 1);

    // Fill to capacity, then one pop re-opens a slot at address 0.
    do_reset();
    req_valid = 2'b01;
    for (int k = 0; k < DEPTH; k++) begin
      req_operand_a[0] = operand_t'(k);
      step();
    end
    cmp("full_flag", full, 1);
    cmp("full_req_ready", req_ready, 2'b00);
    cmp("full_count_pre", count, 31);
    step();
    cmp("full_no_accept", load_en, 0);
    cmp("full_count", count, 32);
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    cmp("full_after_pop", full, 0);
    cmp("full_pop_count", count, 31);
    cmp("full_pop_rp", read_pointer, 1);
    cmp("full_ready_back", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    cmp("wrap_load_en", load_en, 1);
    cmp("wrap_wp", write_pointer, 0);

    // Commit and pop on the same edge with five committed entries.
    do_reset();
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) step();
    req_valid = 2'b00;
    step();
    cmp("sim_count_pre", count, 5);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    cmp("sim_count", count, 5);
    cmp("sim_rp", read_pointer, 1);

    // DEPTH 4 ring: five writes with continuous pops wrap the write address.
    do_reset();
    q_valid = 2'b01;
    q_pop_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      cmp("d4_load_en", q_load_en, 1);
      cmp("d4_wp", q_wp, exp_q[k]);
    end
    q_valid = 2'b00;
    step();
    step();
    q_pop_ready = 1'b0;
    cmp("d4_count", q_count, 0);

    // Mixed request/pop vectors, checked by the model every cycle.
    for (int i = 0; i < 160; i++) begin
      req_valid        = tv_valid[i % 8];
      pop_ready        = tv_pop[i % 8];
      req_opcode[0]    = opcode_t'(4'(i % 8));
      req_opcode[1]    = opcode_t'(4'((i + 3) % 8));
      req_operand_a[0] = operand_t'(i);
      req_operand_a[1] = operand_t'(i * 3);
      req_operand_b[0] = operand_t'(1000 - i);
      req_operand_b[1] = operand_t'(i + 7);
      step();
    end
    req_valid = 2'b00;
    pop_ready = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
